// File: rtl/polara_loopback_packet_check.sv
// -----------------------------------------------------------------------------
// polara_loopback_packet_check
//
// Receive-side checker for the Polara loopback path. It consumes one NoC
// channel of flits coming back from the chip, checks every packet against the
// loopback generator's pattern, and reports packet/error counts together with
// sticky pass/fail status. Instantiate one per NoC channel (noc1..noc3).
//
// Packet format
//   header  : len = data[29:22] (payload flits), msg_type = data[21:14]
//   payload : flit k of packet n = {n[31:0], k[31:0]}, where n is the current
//             packet count (zero-extended) and therefore wraps with pkt_cnt.
//
// Ports
//   chipset_clk        in   1      single clock, all logic on the rising edge
//   chip_rst           in   1      synchronous reset, active-high
//   check_en           in   1      enables acceptance and the timeout counter
//   march              in   1      1 = throttle rdy to every other cycle
//   intf_chipset_data  in   64     flit from the chip interface
//   intf_chipset_val   in   1      flit valid
//   intf_chipset_rdy   out  1      checker ready (registered)
//   pkt_cnt            out  CNT_W  packets completed (wraps)
//   err_cnt            out  ERR_W  errors detected (saturates at all-ones)
//   pass               out  1      sticky: enough clean packets, no errors
//   fail               out  1      sticky: set on the first error
//   err_flit           out  64     first offending flit after reset
// -----------------------------------------------------------------------------
module polara_loopback_packet_check #(
    parameter logic [7:0]  MAX_LEN      = 8'd8,
    parameter logic [7:0]  EXP_MSG_TYPE = 8'd1,
    parameter int unsigned PASS_PKTS    = 16,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ERR_W        = 8
) (
    input  logic             chipset_clk,
    input  logic             chip_rst,
    input  logic             check_en,
    input  logic             march,
    input  logic [63:0]      intf_chipset_data,
    input  logic             intf_chipset_val,
    output logic             intf_chipset_rdy,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             pass,
    output logic             fail,
    output logic [63:0]      err_flit
);

    // Timeout counter only has to reach TIMEOUT-1.
    localparam int unsigned   TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } state_t;

    // -------------------------------------------------------------------------
    // Ready generation
    // -------------------------------------------------------------------------
    logic phase_q;
    logic phase_d;
    logic accept;

    // Phase free-runs while marching and parks at 0 otherwise, so the first
    // marching cycle after march rises is always a "not ready" cycle.
    assign phase_d = march ? ~phase_q : 1'b0;
    assign accept  = intf_chipset_val & intf_chipset_rdy;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge chipset_clk) begin
        if (chip_rst) begin
            phase_q          <= 1'b0;
            intf_chipset_rdy <= 1'b0;
        end else begin
            phase_q          <= phase_d;
            intf_chipset_rdy <= check_en & (~march | ~phase_d);
        end
    end

    // -------------------------------------------------------------------------
    // Packet FSM
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      k_q, k_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_event;
    logic            pkt_done;

    logic [7:0]      hdr_len;
    logic [7:0]      hdr_type;
    logic [63:0]     exp_flit;

    assign hdr_len  = intf_chipset_data[29:22];
    assign hdr_type = intf_chipset_data[21:14];
    assign exp_flit = {32'(pkt_cnt), 32'(k_q)};

    always_ff @(posedge chipset_clk) begin
        if (chip_rst) begin
            state_q <= ST_IDLE;
            len_q   <= 8'd0;
            k_q     <= 8'd0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            k_q     <= k_d;
            to_q    <= to_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        k_d       = k_q;
        to_d      = to_q;
        err_event = 1'b0;
        pkt_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                to_d = '0;
                if (accept) begin
                    if (hdr_type != EXP_MSG_TYPE || hdr_len > MAX_LEN) begin
                        // Malformed header: flag it and keep hunting for a header.
                        err_event = 1'b1;
                    end else if (hdr_len == 8'd0) begin
                        pkt_done = 1'b1;
                    end else begin
                        len_d   = hdr_len;
                        k_d     = 8'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (accept) begin
                    to_d = '0;
                    // A bad payload flit is recorded but the packet is walked to
                    // its end so the following header is still found.
                    if (intf_chipset_data != exp_flit) begin
                        err_event = 1'b1;
                    end
                    if (k_q == len_q - 8'd1) begin
                        pkt_done = 1'b1;
                        k_d      = 8'd0;
                        state_d  = ST_IDLE;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end else if (check_en) begin
                    // Idle cycles with the checker disabled do not age the packet.
                    if (to_q == TO_LAST) begin
                        err_event = 1'b1;
                        to_d      = '0;
                        k_d       = 8'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters and status
    // -------------------------------------------------------------------------
    always_ff @(posedge chipset_clk) begin
        if (chip_rst) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            err_flit <= 64'd0;
        end else begin
            if (pkt_done) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end

            if (err_event) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                fail <= 1'b1;
                // Keep the very first culprit; on a timeout this is whatever
                // sits on the bus at that moment.
                if (!fail) begin
                    err_flit <= intf_chipset_data;
                end
            end

            // Evaluated from the registered counters, hence one cycle behind
            // the pkt_cnt update; fail overrides and pins pass low.
            pass <= ~fail & (pass | ((pkt_cnt >= CNT_W'(PASS_PKTS)) && (err_cnt == '0)));
        end
    end

endmodule

// File: tb/tb_polara_loopback_packet_check.sv
// -----------------------------------------------------------------------------
// tb_polara_loopback_packet_check
//
// Directed bench for polara_loopback_packet_check. Inputs are driven 1 ns after
// the rising edge and outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_polara_loopback_packet_check;

    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        chip_rst;
    logic        check_en;
    logic        march;
    logic [63:0] data;
    logic        val;
    logic        rdy;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;
    logic        pass;
    logic        fail;
    logic [63:0] err_flit;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    polara_loopback_packet_check dut (
        .chipset_clk       (clk),
        .chip_rst          (chip_rst),
        .check_en          (check_en),
        .march             (march),
        .intf_chipset_data (data),
        .intf_chipset_val  (val),
        .intf_chipset_rdy  (rdy),
        .pkt_cnt           (pkt_cnt),
        .err_cnt           (err_cnt),
        .pass              (pass),
        .fail              (fail),
        .err_flit          (err_flit)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] len, input logic [7:0] typ);
        logic [63:0] h;
        h        = 64'hA500_0000_0000_0000;   // unrelated bits must be ignored
        h[29:22] = len;
        h[21:14] = typ;
        return h;
    endfunction

    function automatic logic [63:0] pl(input int unsigned n, input int unsigned k);
        return {n[31:0], k[31:0]};
    endfunction

    // Present one flit and hold it until the checker takes it.
    task automatic send(input logic [63:0] d);
        int waited;
        waited = 0;
        data = d;
        val  = 1'b1;
        while (!rdy && waited < 20) begin
            tick();
            waited++;
        end
        if (!rdy) begin
            tests_run++;
            tests_failed++;
            $error("FAIL send_rdy_timeout: observed rdy=0 for 20 cycles expected rdy=1");
        end
        tick();
        val = 1'b0;
    endtask

    task automatic do_reset(input logic march_v);
        chip_rst = 1'b1;
        march    = march_v;
        val      = 1'b0;
        repeat (4) tick();
        chip_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        logic pre;
        logic [63:0] flits [3];

        check_en = 1'b1;
        march    = 1'b0;
        data     = 64'd0;
        val      = 1'b0;
        chip_rst = 1'b1;

        // ---- 1: reset state, rdy one cycle after release ----
        repeat (4) tick();
        check("rst_rdy",      64'(rdy),      64'd0);
        check("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
        check("rst_err_cnt",  64'(err_cnt),  64'd0);
        check("rst_pass",     64'(pass),     64'd0);
        check("rst_fail",     64'(fail),     64'd0);
        check("rst_err_flit", err_flit,      64'd0);
        chip_rst = 1'b0;
        tick();
        check("rel_rdy",      64'(rdy),      64'd1);
        check("rel_pkt_cnt",  64'(pkt_cnt),  64'd0);

        // ---- 2: 16 clean len=2 packets -> pass one cycle after last tail ----
        for (int n = 0; n < 16; n++) begin
            send(hdr(8'd2, 8'd1));
            send(pl(n, 0));
            send(pl(n, 1));
            if (n == 0) check("s2_first_pkt", 64'(pkt_cnt), 64'd1);
        end
        check("s2_pkt_cnt",    64'(pkt_cnt), 64'd16);
        check("s2_err_cnt",    64'(err_cnt), 64'd0);
        check("s2_pass_early", 64'(pass),    64'd0);
        tick();
        check("s2_pass",       64'(pass),    64'd1);
        // Boundary lengths: len=MAX_LEN (n=16) then len=0.
        send(hdr(8'd8, 8'd1));
        for (int k = 0; k < 8; k++) send(pl(16, k));
        check("s2_maxlen_pkt", 64'(pkt_cnt), 64'd17);
        send(hdr(8'd0, 8'd1));
        check("s2_len0_pkt",   64'(pkt_cnt), 64'd18);
        check("s2_err_after",  64'(err_cnt), 64'd0);
        check("s2_pass_held",  64'(pass),    64'd1);

        // ---- 3: bad payload, then oversize and wrong-type headers ----
        do_reset(1'b0);
        send(hdr(8'd1, 8'd1));
        send(64'h0000_0000_0000_0005);
        check("s3_err_cnt",  64'(err_cnt), 64'd1);
        check("s3_fail",     64'(fail),    64'd1);
        check("s3_err_flit", err_flit,     64'h5);
        check("s3_pkt_cnt",  64'(pkt_cnt), 64'd1);
        tick();
        check("s3_pass",     64'(pass),    64'd0);
        send(hdr(8'd9, 8'd1));
        check("s3_len9_err", 64'(err_cnt), 64'd2);
        check("s3_len9_pkt", 64'(pkt_cnt), 64'd1);
        check("s3_flit_kept", err_flit,    64'h5);
        send(hdr(8'd0, 8'd2));
        check("s3_type_err", 64'(err_cnt), 64'd3);
        send(hdr(8'd0, 8'd1));
        check("s3_idle_pkt", 64'(pkt_cnt), 64'd2);

        // ---- 4: march throttling, val held high ----
        do_reset(1'b1);
        tick();
        check("s4_rdy_first", 64'(rdy), 64'd0);
        flits[0] = hdr(8'd2, 8'd1);
        flits[1] = pl(0, 0);
        flits[2] = pl(0, 1);
        acc  = 0;
        data = flits[0];
        val  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            pre = rdy;
            tick();
            if (pre) begin
                acc++;
                if (acc < 3) data = flits[acc];
                else         val  = 1'b0;
            end
            check("s4_rdy_alt", 64'(rdy), (c % 2 == 0) ? 64'd1 : 64'd0);
        end
        check("s4_accepts", 64'(acc),     64'd3);
        check("s4_pkt0",    64'(pkt_cnt), 64'd1);
        for (int n = 1; n < 16; n++) begin
            send(hdr(8'd2, 8'd1));
            send(pl(n, 0));
            send(pl(n, 1));
        end
        check("s4_pkt_cnt",    64'(pkt_cnt), 64'd16);
        check("s4_err_cnt",    64'(err_cnt), 64'd0);
        check("s4_pass_early", 64'(pass),    64'd0);
        tick();
        check("s4_pass",       64'(pass),    64'd1);

        // ---- 5: mid-packet timeout ----
        do_reset(1'b0);
        send(hdr(8'd3, 8'd1));
        send(pl(0, 0));
        data = 64'hDEAD_BEEF_CAFE_0001;
        repeat (TIMEOUT - 1) tick();
        check("s5_no_err_yet", 64'(err_cnt), 64'd0);
        tick();
        check("s5_err_cnt",  64'(err_cnt), 64'd1);
        check("s5_fail",     64'(fail),    64'd1);
        check("s5_err_flit", err_flit,     64'hDEAD_BEEF_CAFE_0001);
        check("s5_pkt_cnt",  64'(pkt_cnt), 64'd0);
        // Back in IDLE: a len=0 header completes a packet with no new error.
        send(hdr(8'd0, 8'd1));
        check("s5_idle_pkt", 64'(pkt_cnt), 64'd1);
        check("s5_idle_err", 64'(err_cnt), 64'd1);

        // ---- 6: reset mid-payload, then fresh headers ----
        do_reset(1'b0);
        send(hdr(8'd2, 8'd1));
        send(pl(0, 0));
        chip_rst = 1'b1;
        tick();
        tick();
        chip_rst = 1'b0;
        check("s6_rst_pkt", 64'(pkt_cnt), 64'd0);
        send(hdr(8'd0, 8'd1));
        check("s6_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("s6_err_cnt", 64'(err_cnt), 64'd0);
        check("s6_fail",    64'(fail),    64'd0);
        send(hdr(8'd0, 8'd2));
        check("s6_type_err", 64'(err_cnt), 64'd1);
        check("s6_type_pkt", 64'(pkt_cnt), 64'd1);
        send(hdr(8'd0, 8'd1));
        check("s6_still_idle", 64'(pkt_cnt), 64'd2);
        check("s6_err_same",   64'(err_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
